// File: rtl/vid_timing_pkg.sv
// Shared constants, types and helpers for the raster timing generator.
package vid_timing_pkg;

  // XGA 1024x768 at 60 Hz.
  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;
  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;

  // SE-native 512x342 raster, 704 x 370 totals.
  localparam int unsigned SE_H_ACTIVE = 512;
  localparam int unsigned SE_H_FP     = 16;
  localparam int unsigned SE_H_SYNC   = 160;
  localparam int unsigned SE_H_BP     = 16;
  localparam int unsigned SE_V_ACTIVE = 342;
  localparam int unsigned SE_V_FP     = 2;
  localparam int unsigned SE_V_SYNC   = 4;
  localparam int unsigned SE_V_BP     = 22;

  // Position of a fetch pixel within its VRAM slot period.
  typedef enum logic [1:0] {
    SLOT_READ,
    SLOT_IDLE,
    SLOT_WRITE
  } slot_phase_e;

  // Single-bit registered outputs, decoded together from the next raster position.
  typedef struct packed {
    logic hSync;
    logic vSync;
    logic vidActive;
    logic fetchActive;
    logic frameStart;
    logic lineStart;
    logic vblankStart;
    logic readSlot;
    logic writeSlot;
  } vid_flags_t;

  function automatic int unsigned hTotal(int unsigned active, int unsigned fp,
                                         int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned vTotal(int unsigned active, int unsigned fp,
                                         int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Fetch words per displayed line: one read slot covers 2^slotBits pixels.
  function automatic int unsigned bytesPerLine(int unsigned hActive, int unsigned slotBits);
    return hActive >> slotBits;
  endfunction

  // Output values while stopped or in reset: syncs inactive, everything else low.
  function automatic vid_flags_t idleFlags(logic hPol, logic vPol);
    vid_flags_t f;
    f       = '0;
    f.hSync = ~hPol;
    f.vSync = ~vPol;
    return f;
  endfunction

endpackage

// File: rtl/vid_timing_gen_if.sv
// Timing generator bundle: control inputs plus raster, slot and buffer outputs.
interface vid_timing_gen_if #(
  parameter int unsigned H_W    = 11,
  parameter int unsigned V_W    = 10,
  parameter int unsigned ADDR_W = 15
);
  logic              enable;
  logic              bufSelReq;
  logic [H_W-1:0]    hCount;
  logic [V_W-1:0]    vCount;
  logic              hSync;
  logic              vSync;
  logic              vidActive;
  logic              fetchActive;
  logic              frameStart;
  logic              lineStart;
  logic              vblankStart;
  logic              readSlot;
  logic              writeSlot;
  logic [ADDR_W-1:0] fetchAddr;
  logic              bufSel;
  logic              bufSelAck;

  // Generator side.
  modport master (
    input  enable, bufSelReq,
    output hCount, vCount, hSync, vSync, vidActive, fetchActive, frameStart, lineStart,
           vblankStart, readSlot, writeSlot, fetchAddr, bufSel, bufSelAck
  );

  // Consumer side (arbiter, shifter, host).
  modport slave (
    output enable, bufSelReq,
    input  hCount, vCount, hSync, vSync, vidActive, fetchActive, frameStart, lineStart,
           vblankStart, readSlot, writeSlot, fetchAddr, bufSel, bufSelAck
  );
endinterface

// File: rtl/vid_fetch_addr.sv
// Linear VRAM fetch address counter with line-repeat rewind.
// All inputs describe the raster position that becomes current on the next edge.
module vid_fetch_addr #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned BPL        = 64,
  parameter int unsigned START_ADDR = 1
) (
  input  logic              pixClk,
  input  logic              nReset,
  input  logic              enable,
  input  logic              readNext,
  input  logic              firstNext,
  input  logic              lineEndNext,
  input  logic              repeatNext,
  output logic [ADDR_W-1:0] fetchAddr
);
  localparam logic [ADDR_W-1:0] Bpl       = ADDR_W'(BPL);
  // The first enabled frame starts fetching FETCH_LEAD pixels into line 0,
  // so the counter is parked at that word while stopped.
  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

  logic [ADDR_W-1:0] cntQ, cntD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [ADDR_W-1:0] issue;

  // Pick the address for the next read and advance or rewind the counter.
  always_comb begin
    issue = firstNext ? '0 : cntQ;
    cntD  = cntQ;
    addrD = addrQ;
    if (!enable) begin
      cntD  = StartAddr;
      addrD = '0;
    end else if (readNext) begin
      addrD = issue;
      cntD  = issue + 1'b1;
      // Repeated lines re-read the same span of words.
      if (lineEndNext && repeatNext) begin
        cntD = issue + 1'b1 - Bpl;
      end
    end
  end

  // Counter and registered address.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      cntQ  <= StartAddr;
      addrQ <= '0;
    end else begin
      cntQ  <= cntD;
      addrQ <= addrD;
    end
  end

  assign fetchAddr = addrQ;

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised raster timing generator and VRAM slot scheduler.
// Every output is decoded from the next counter state and registered, so all
// outputs line up with the hCount/vCount presented in the same cycle.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = XGA_H_ACTIVE,
  parameter int unsigned H_FP       = XGA_H_FP,
  parameter int unsigned H_SYNC     = XGA_H_SYNC,
  parameter int unsigned H_BP       = XGA_H_BP,
  parameter int unsigned V_ACTIVE   = XGA_V_ACTIVE,
  parameter int unsigned V_FP       = XGA_V_FP,
  parameter int unsigned V_SYNC     = XGA_V_SYNC,
  parameter int unsigned V_BP       = XGA_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned FETCH_LEAD = 16,
  parameter int unsigned H_W        = 11,
  parameter int unsigned V_W        = 10,
  parameter int unsigned ADDR_W     = 15
) (
  input logic              pixClk,
  input logic              nReset,
  vid_timing_gen_if.master vif
);
  localparam int unsigned SLOT_BITS = 3 + SCALE_LOG2;
  localparam int unsigned H_TOTAL   = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL   = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned BPL       = bytesPerLine(H_ACTIVE, SLOT_BITS);
  localparam int unsigned LAST_ADDR = ((V_ACTIVE - 1) >> SCALE_LOG2) * BPL + BPL - 1;

  localparam logic [H_W-1:0] HLast     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] HActive   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HSyncBeg  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W:0]   HSyncEnd  = (H_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W:0]   HTotalX   = (H_W + 1)'(H_TOTAL);
  localparam logic [H_W:0]   FetchLead = (H_W + 1)'(FETCH_LEAD);
  localparam logic [H_W-1:0] LastReadF = H_W'(H_ACTIVE - (1 << SLOT_BITS));
  localparam logic [V_W-1:0] VLast     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] VActive   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VSyncBeg  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W:0]   VSyncEnd  = (V_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
  // Low fetch-line bits that are all ones on the last repeat of a source line.
  localparam logic [V_W-1:0] RepMask   = V_W'((1 << SCALE_LOG2) - 1);
  localparam logic [SLOT_BITS-1:0] WritePhase = SLOT_BITS'(1 << (SLOT_BITS - 1));
  localparam vid_flags_t     IdleFlags = idleFlags(H_SYNC_POL, V_SYNC_POL);

  // Illegal parameter sets stop elaboration.
  if ((FETCH_LEAD % (1 << SLOT_BITS)) != 0 || FETCH_LEAD >= H_ACTIVE) begin : gen_bad_lead
    $error("FETCH_LEAD must be a multiple of 2^SLOT_BITS and below H_ACTIVE");
  end
  if ((H_ACTIVE % (1 << SLOT_BITS)) != 0) begin : gen_bad_hactive
    $error("H_ACTIVE must be a multiple of 2^SLOT_BITS");
  end
  if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W)) begin : gen_bad_counts
    $error("H_TOTAL/V_TOTAL do not fit H_W/V_W");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : gen_bad_sync
    $error("sync widths must be non-zero");
  end
  if (LAST_ADDR >= (1 << ADDR_W)) begin : gen_bad_addr
    $error("last fetch address does not fit ADDR_W");
  end

  logic [H_W-1:0] hCountQ, hNext;
  logic [V_W-1:0] vCountQ, vNext;
  logic [H_W:0]   fSum;
  logic           fWrap;
  logic [H_W-1:0] fPos;
  logic [V_W-1:0] fLine;
  slot_phase_e    slotPhase;
  vid_flags_t     flagsQ, flagsD;
  logic           bufSelQ, bufSelD;
  logic           bufSelAckQ, bufSelAckD;
  logic           firstFetch, lineEnd, lineRepeat;

  // Next raster position; stopping parks the counters at pre-frame.
  always_comb begin
    hNext = HLast;
    vNext = VLast;
    if (vif.enable) begin
      if (hCountQ == HLast) begin
        hNext = '0;
        vNext = (vCountQ == VLast) ? '0 : vCountQ + 1'b1;
      end else begin
        hNext = hCountQ + 1'b1;
        vNext = vCountQ;
      end
    end
  end

  // Fetch position runs FETCH_LEAD pixels ahead and may spill into the next line.
  always_comb begin
    fSum  = {1'b0, hNext} + FetchLead;
    fWrap = (fSum >= HTotalX);
    fPos  = fWrap ? H_W'(fSum - HTotalX) : fSum[H_W-1:0];
    fLine = vNext;
    if (fWrap) begin
      fLine = (vNext == VLast) ? '0 : vNext + 1'b1;
    end
  end

  // Slot phase of the fetch pixel.
  always_comb begin
    slotPhase = SLOT_IDLE;
    if (fPos[SLOT_BITS-1:0] == '0) begin
      slotPhase = SLOT_READ;
    end else if (fPos[SLOT_BITS-1:0] == WritePhase) begin
      slotPhase = SLOT_WRITE;
    end
  end

  // Decode windows, pulses and slots for the next position.
  always_comb begin
    flagsD = IdleFlags;
    if (vif.enable) begin
      flagsD.hSync       = (hNext >= HSyncBeg && {1'b0, hNext} < HSyncEnd) ?
                           H_SYNC_POL : ~H_SYNC_POL;
      flagsD.vSync       = (vNext >= VSyncBeg && {1'b0, vNext} < VSyncEnd) ?
                           V_SYNC_POL : ~V_SYNC_POL;
      flagsD.vidActive   = (hNext < HActive) && (vNext < VActive);
      flagsD.fetchActive = (fPos < HActive) && (fLine < VActive);
      flagsD.frameStart  = (hNext == '0) && (vNext == '0);
      flagsD.lineStart   = (hNext == '0);
      flagsD.vblankStart = (hNext == '0) && (vNext == VActive);
      flagsD.readSlot    = flagsD.fetchActive && (slotPhase == SLOT_READ);
      flagsD.writeSlot   = (slotPhase == SLOT_WRITE);
    end
  end

  // Buffer select commits only on the edge that enters vblank.
  always_comb begin
    bufSelD    = bufSelQ;
    bufSelAckD = 1'b0;
    if (flagsD.vblankStart) begin
      bufSelD    = vif.bufSelReq;
      bufSelAckD = vif.bufSelReq ^ bufSelQ;
    end
  end

  // Raster counters and all decoded outputs.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      hCountQ    <= HLast;
      vCountQ    <= VLast;
      flagsQ     <= IdleFlags;
      bufSelQ    <= 1'b0;
      bufSelAckQ <= 1'b0;
    end else begin
      hCountQ    <= hNext;
      vCountQ    <= vNext;
      flagsQ     <= flagsD;
      bufSelQ    <= bufSelD;
      bufSelAckQ <= bufSelAckD;
    end
  end

  assign firstFetch = (fPos == '0) && (fLine == '0);
  assign lineEnd    = (fPos == LastReadF);
  assign lineRepeat = (fLine & RepMask) != RepMask;

  vid_fetch_addr #(
    .ADDR_W     (ADDR_W),
    .BPL        (BPL),
    .START_ADDR (FETCH_LEAD >> SLOT_BITS)
  ) uFetchAddr (
    .pixClk      (pixClk),
    .nReset      (nReset),
    .enable      (vif.enable),
    .readNext    (flagsD.readSlot),
    .firstNext   (firstFetch),
    .lineEndNext (lineEnd),
    .repeatNext  (lineRepeat),
    .fetchAddr   (vif.fetchAddr)
  );

  assign vif.hCount      = hCountQ;
  assign vif.vCount      = vCountQ;
  assign vif.hSync       = flagsQ.hSync;
  assign vif.vSync       = flagsQ.vSync;
  assign vif.vidActive   = flagsQ.vidActive;
  assign vif.fetchActive = flagsQ.fetchActive;
  assign vif.frameStart  = flagsQ.frameStart;
  assign vif.lineStart   = flagsQ.lineStart;
  assign vif.vblankStart = flagsQ.vblankStart;
  assign vif.readSlot    = flagsQ.readSlot;
  assign vif.writeSlot   = flagsQ.writeSlot;
  assign vif.bufSel      = bufSelQ;
  assign vif.bufSelAck   = bufSelAckQ;

endmodule
